led_panel_receiver: RTL and testbench

LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

---
 rtl/led_panel_receiver.sv | 149 ++++++++++++++
 tb/tb_led_panel_receiver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_receiver.sv
// rtl/led_panel_receiver.sv - panel-side receiver: synchronizes shift/latch traffic into a row-pair framebuffer
module led_panel_receiver #(
  parameter int COLS = 32,
  parameter int ROWS = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_lp_clock,
  input  logic                          i_lp_latch,
  input  logic                          i_lp_blank,
  input  logic [2:0]                    i_lp_rgb_0,
  input  logic [2:0]                    i_lp_rgb_1,
  input  logic [4:0]                    i_lp_address,
  input  logic [$clog2(COLS)-1:0]       i_read_x,
  input  logic [$clog2(ROWS)-1:0]       i_read_y,
  output logic [2:0]                    o_read_rgb,
  output logic                          o_row_valid,
  output logic [$clog2(ROWS/2)-1:0]     o_row_address,
  output logic                          o_frame_pulse,
  output logic                          o_blank,
  output logic                          o_shift_error
);

  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int HALF = ROWS / 2;
  localparam int AW   = $clog2(HALF);
  localparam int CW   = XW + 1;
  localparam int SW   = 14;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_COMMIT = 1'b1;

  logic [SW-1:0]            lp_in;
  logic [SW-1:0]            sync_1;
  logic [SW-1:0]            sync_2;
  logic [1:0]               hist;
  logic                     s_clock;
  logic                     s_latch;
  logic [2:0]               s_rgb_0;
  logic [2:0]               s_rgb_1;
  logic [4:0]               s_address;
  logic                     clock_rise;
  logic                     latch_fall;
  logic [0:0]               state;
  logic                     commit;
  logic [AW-1:0]            commit_addr;
  logic [YW-1:0]            row_lo;
  logic [YW-1:0]            row_hi;
  logic [5:0]               sample;
  logic [CW-1:0]            shift_count;
  logic [5:0][COLS-1:0]     shreg;
  logic [2:0][COLS-1:0]     fb [ROWS];

  // All panel inputs share one synchronizer so data stays aligned with its clock edge.
  assign lp_in     = {i_lp_address, i_lp_rgb_1, i_lp_rgb_0, i_lp_blank, i_lp_latch, i_lp_clock};
  assign s_clock   = sync_2[0];
  assign s_latch   = sync_2[1];
  assign o_blank   = sync_2[2];
  assign s_rgb_0   = sync_2[5:3];
  assign s_rgb_1   = sync_2[8:6];
  assign s_address = sync_2[13:9];

  assign clock_rise  = s_clock & ~hist[0];
  assign latch_fall  = ~s_latch & hist[1];
  assign commit      = (state == S_COMMIT);
  assign commit_addr = AW'(int'(s_address) % HALF);
  assign row_lo      = YW'(commit_addr);
  assign row_hi      = YW'(int'(commit_addr) + HALF);
  assign sample      = {s_rgb_1, s_rgb_0};

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      hist   <= '0;
    end else begin
      sync_1 <= lp_in;
      sync_2 <= sync_1;
      hist   <= {s_latch, s_clock};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else if (state == S_IDLE && latch_fall) begin
      state <= S_COMMIT;
    end else begin
      state <= S_IDLE;
    end
  end

  // Planes 0..2 are r0,g0,b0 (upper half), 3..5 are r1,g1,b1 (lower half); bit index is column.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      shreg <= '0;
    end else if (clock_rise) begin
      for (int k = 0; k < 6; k++) begin
        shreg[k] <= {shreg[k][COLS-2:0], sample[k]};
      end
    end
  end

  // An edge landing on the commit cycle is the first shift of the next row.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      shift_count <= '0;
    end else if (commit) begin
      shift_count <= clock_rise ? CW'(1) : '0;
    end else if (clock_rise && shift_count != '1) begin
      shift_count <= shift_count + CW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ROWS; i++) begin
        fb[i] <= '0;
      end
      o_read_rgb <= '0;
    end else begin
      if (commit) begin
        fb[row_lo] <= shreg[2:0];
        fb[row_hi] <= shreg[5:3];
      end
      o_read_rgb <= {fb[i_read_y][2][i_read_x], fb[i_read_y][1][i_read_x], fb[i_read_y][0][i_read_x]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_row_valid   <= 1'b0;
      o_row_address <= '0;
      o_frame_pulse <= 1'b0;
      o_shift_error <= 1'b0;
    end else begin
      o_row_valid   <= commit;
      o_frame_pulse <= commit && (commit_addr == AW'(HALF - 1));
      if (commit) begin
        o_row_address <= commit_addr;
        if (shift_count != CW'(COLS)) begin
          o_shift_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_panel_receiver.sv
// tb/tb_led_panel_receiver.sv - randomized bench for led_panel_receiver against a pixel-history model
module tb_led_panel_receiver;

  localparam int COLS = 32;
  localparam int ROWS = 16;
  localparam int HALF = ROWS / 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       lp_clock;
  logic       lp_latch;
  logic       lp_blank;
  logic [2:0] lp_rgb_0;
  logic [2:0] lp_rgb_1;
  logic [4:0] lp_address;
  logic [4:0] read_x;
  logic [3:0] read_y;
  logic [2:0] read_rgb;
  logic       row_valid;
  logic [2:0] row_address;
  logic       frame_pulse;
  logic       blank;
  logic       shift_error;

  led_panel_receiver #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clock       (clock),
    .i_reset_n     (reset_n),
    .i_lp_clock    (lp_clock),
    .i_lp_latch    (lp_latch),
    .i_lp_blank    (lp_blank),
    .i_lp_rgb_0    (lp_rgb_0),
    .i_lp_rgb_1    (lp_rgb_1),
    .i_lp_address  (lp_address),
    .i_read_x      (read_x),
    .i_read_y      (read_y),
    .o_read_rgb    (read_rgb),
    .o_row_valid   (row_valid),
    .o_row_address (row_address),
    .o_frame_pulse (frame_pulse),
    .o_blank       (blank),
    .o_shift_error (shift_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: the last COLS pixels shifted per half; newest pixel sits at column 0.
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         m_count;
  bit         m_err;
  logic [2:0] m_fb [ROWS][COLS];
  int         exp_addr[$];
  int         pulses = 0;
  int         frames = 0;
  int         mon_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] reg_col(input logic [2:0] q[$], input int c);
    if (c < q.size()) return q[q.size() - 1 - c];
    return 3'b000;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_count = 0;
    m_err = 0;
    exp_addr.delete();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) m_fb[y][x] = 3'b000;
  endtask

  task automatic model_commit(input int a);
    for (int c = 0; c < COLS; c++) begin
      m_fb[a][c] = reg_col(q0, c);
      m_fb[a + HALF][c] = reg_col(q1, c);
    end
    if (m_count != COLS) m_err = 1;
    m_count = 0;
    exp_addr.push_back(a);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [2:0] p0, input logic [2:0] p1, input int hi, input int lo);
    lp_rgb_0 = p0;
    lp_rgb_1 = p1;
    lp_clock = 1'b1;
    tick(hi);
    lp_clock = 1'b0;
    tick(lo);
    q0.push_back(p0);
    q1.push_back(p1);
    if (q0.size() > COLS) void'(q0.pop_front());
    if (q1.size() > COLS) void'(q1.pop_front());
    m_count++;
  endtask

  task automatic send_latch(input logic [4:0] addr, input int hi);
    lp_address = addr;
    lp_blank = 1'($urandom);
    lp_latch = 1'b1;
    tick(hi);
    lp_latch = 1'b0;
    tick(1);
    model_commit(int'(addr) % HALF);
  endtask

  task automatic send_row(input int a, input int n, input int hi, input int lo, input int lhi);
    for (int i = 0; i < n; i++) send_pixel(3'($urandom), 3'($urandom), hi, lo);
    send_latch(5'(a + HALF * $urandom_range(0, 3)), lhi);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_addr.size() != 0; i++) tick(1);
    check("commit_drain", 32'(exp_addr.size()), 32'd0);
    tick(2);
  endtask

  task automatic read_px(input int x, input int y, output logic [2:0] v);
    read_x = 5'(x);
    read_y = 4'(y);
    @(posedge clock);
    @(negedge clock);
    v = read_rgb;
  endtask

  task automatic verify_fb();
    logic [2:0] v;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        read_px(x, y, v);
        check($sformatf("fb[%0d][%0d]", y, x), 32'(v), 32'(m_fb[y][x]));
      end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (row_valid !== 1'b0) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_row_valid", 32'(row_valid), 32'd0);
        end else begin
          mon_a = exp_addr.pop_front();
          check("row_address", 32'(row_address), 32'(mon_a));
          check("frame_pulse", 32'(frame_pulse), 32'(mon_a == HALF - 1));
          pulses++;
          if (frame_pulse === 1'b1) frames++;
        end
      end else if (frame_pulse !== 1'b0) begin
        check("stray_frame_pulse", 32'(frame_pulse), 32'd0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0] v;
    logic [2:0] old_v;
    logic [2:0] pix[COLS];
    int p0, f0, rx;
    bit seen;

    reset_n = 1'b0;
    lp_clock = 1'b0;
    lp_latch = 1'b0;
    lp_blank = 1'b0;
    lp_rgb_0 = '0;
    lp_rgb_1 = '0;
    lp_address = '0;
    read_x = '0;
    read_y = '0;
    tick(3);
    @(negedge clock);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_frame_pulse", 32'(frame_pulse), 32'd0);
    check("rst_shift_error", 32'(shift_error), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_read_rgb", 32'(read_rgb), 32'd0);
    check("rst_row_address", 32'(row_address), 32'd0);
    reset_n = 1'b1;
    model_reset();
    tick(2);

    // Single green dot at column 31 of row 3.
    send_pixel(3'b010, 3'b000, 1, 1);
    for (int i = 0; i < COLS - 1; i++) send_pixel(3'b000, 3'b000, 1, 1);
    send_latch(5'd3, 1);
    drain();
    read_px(31, 3, v); check("dot_31_3", 32'(v), 32'h2);
    read_px(30, 3, v); check("dot_30_3", 32'(v), 32'h0);
    read_px(31, 11, v); check("dot_31_11", 32'(v), 32'h0);
    check("dot_shift_error", 32'(shift_error), 32'd0);

    // Full frame with randomized slow timing.
    p0 = pulses; f0 = frames;
    for (int a = 0; a < HALF; a++)
      send_row(a, COLS, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
    drain();
    check("frame_rows", 32'(pulses - p0), 32'd8);
    check("frame_pulses", 32'(frames - f0), 32'd1);
    check("frame_shift_error", 32'(shift_error), 32'd0);
    verify_fb();

    // Back-to-back transmitter timing; next row's first edge lands on the commit cycle.
    p0 = pulses; f0 = frames;
    for (int a = HALF - 1; a >= 0; a--) send_row(a, COLS, 1, 1, 1);
    drain();
    check("tx_rows", 32'(pulses - p0), 32'd8);
    check("tx_frames", 32'(frames - f0), 32'd1);
    check("tx_shift_error", 32'(shift_error), 32'd0);
    verify_fb();

    // Read row 5 while it is being committed.
    rx = $urandom_range(0, COLS - 1);
    old_v = m_fb[5][rx];
    for (int i = 0; i < COLS; i++) pix[i] = 3'($urandom);
    pix[COLS - 1 - rx] = ~old_v;
    read_x = 5'(rx);
    read_y = 4'd5;
    for (int i = 0; i < COLS; i++) send_pixel(pix[i], 3'($urandom), 1, 2);
    send_latch(5'd5, 2);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clock);
      if (row_valid === 1'b1) begin
        seen = 1;
        check("read_commit_old", 32'(read_rgb), 32'(old_v));
        @(negedge clock);
        check("read_commit_new", 32'(read_rgb), 32'(m_fb[5][rx]));
      end
    end
    check("read_commit_seen", 32'(seen), 32'd1);
    drain();

    // Short, long and exact rows against the sticky error flag.
    send_row(2, COLS - 1, 1, 1, 1);
    drain();
    check("short_row_error", 32'(shift_error), 32'(m_err));
    check("short_row_error_set", 32'(shift_error), 32'd1);
    send_row(4, COLS, 2, 1, 1);
    drain();
    check("error_sticky", 32'(shift_error), 32'd1);
    send_row(6, 70, 1, 1, 2);
    drain();
    check("long_row_error", 32'(shift_error), 32'(m_err));
    verify_fb();

    // Reset mid-row, with a latch pulse inside reset.
    for (int i = 0; i < 16; i++) send_pixel(3'($urandom), 3'($urandom), 1, 1);
    p0 = pulses;
    reset_n = 1'b0;
    tick(1);
    lp_latch = 1'b1;
    tick(1);
    lp_latch = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_reset();
    tick(8);
    check("no_commit_in_reset", 32'(pulses - p0), 32'd0);
    check("reset_clears_error", 32'(shift_error), 32'd0);
    send_row(0, COLS, $urandom_range(1, 2), $urandom_range(1, 2), 1);
    drain();
    check("post_reset_exact", 32'(shift_error), 32'd0);
    verify_fb();

    // Partial row after reset must not carry pre-reset bits.
    for (int i = 0; i < 10; i++) send_pixel(3'b111, 3'b111, 1, 1);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_reset();
    tick(2);
    for (int i = 0; i < 8; i++) send_pixel(3'($urandom), 3'($urandom), 1, 1);
    send_latch(5'd1, 1);
    drain();
    check("partial_error", 32'(shift_error), 32'(m_err));
    verify_fb();

    for (int i = 0; i < 6; i++) begin
      lp_blank = 1'($urandom);
      tick(3);
      check("blank", 32'(blank), 32'(lp_blank));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
